tnoc_output_arbiter: RTL and testbench
======================================

# tnoc_output_arbiter

Arbitrates packet-level ownership of one router output port among its five input-port requesters. Drives the one-hot grant vector that selects the output switch mux path, and holds each grant for a whole packet until the switch reports that the tail flit has left. Uses a round-robin policy that is fair across back-to-back packets. One instance sits beside each output switch in the router.

## Interface
- `REQUESTERS`, default 5: number of competing input ports. Fixed at 5 in the router; must be ≥2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `i_request`  input  REQUESTERS  bit i high: input port i has a packet routed to this output.
- `i_free`  input  1  from switch `o_output_free`; high for the cycle the tail flit of the current packet is accepted downstream.
- `o_grant`  output  REQUESTERS  one-hot or zero; drives switch `i_output_grant`. Registered.
- `o_busy`  output  1  high while a grant is held; equals `|o_grant`.

## Operation
- Two states:
  - `IDLE`: no grant.
  - `BUSY`: exactly one `o_grant` bit set.
- Round-robin pointer `last` (index of the most recently granted port):
  - Selection scans `last+1, last+2, …` modulo REQUESTERS.
  - The first set request bit wins.
- **IDLE → BUSY**:
  - Trigger: `|i_request`.
  - Effect: winner's grant bit set; `last` ← winner index.
- **BUSY, `i_free` low**:
  - Grant held unchanged.
  - `i_request` is ignored, including the owner deasserting it.
- **BUSY, `i_free` high**:
  - Grant released.
  - Arbitration runs the same cycle over `i_request`, with the owner masked out. The owner's bit is not expected until its next packet.
  - Pending winner → stay BUSY with the new grant.
  - No pending requester → IDLE.
- **`i_free` while IDLE**: ignored, no state change.
- **Index arithmetic**: `last` is `$clog2(REQUESTERS)` bits; increment wraps from REQUESTERS-1 to 0 explicitly (not by power-of-two overflow).
- **Reset values**:
  - `o_grant` = 0, `o_busy` = 0, state = IDLE.
  - `last` = REQUESTERS-1, so port 0 has first priority after reset.
- **Reset asserted mid-packet**: grant cleared immediately (asynchronously); no partial state survives.

## Timing
- **Grant latency**: request first seen high at edge N → `o_grant` valid after edge N (one cycle), in the cycle following the request.
- **Back-to-back handover**: `i_free` high in cycle N → new owner's grant valid in cycle N+1. No bubble cycle between packets of different requesters.
- **Minimum ownership**: one cycle (single-flit packet, `i_free` in the first granted cycle).
- **Path from `i_request`/`i_free` to `o_grant`**: combinational into flops only; `o_grant` is never combinationally dependent on inputs.

## Structure
- Shared package (`tnoc_pkg` or router package) holds:
  - the `REQUESTERS`-wide grant vector typedef;
  - the state enum `{IDLE, BUSY}`, so the router monitor and assertions reuse it.
- Sub-module `tnoc_round_robin_selector`: combinational; inputs request vector and `last`, outputs one-hot winner and winner index.
  - Reused by the virtual-channel arbiter.
- This block contains: state register, `last` register, grant register, release/mask logic.
- Assertions:
  - `o_grant` is `$onehot0`.
  - Grant stable while BUSY and `!i_free`.

## Test plan
- **Reset then single request**: `i_request`=5'b00100 → `o_grant`=5'b00100 one cycle later. Holds for 3 cycles with `i_free`=0; `i_free` pulse → `o_grant`=0 next cycle.
- **Fairness**: all 5 requests held high, `i_free` pulsed every 2nd cycle → grant order 0,1,2,3,4,0. Every port is granted once before any port repeats.
- **Back-to-back handover**: owner 1, requests 5'b01010, `i_free` in cycle N → `o_grant`=5'b01000 in N+1, with no idle cycle.
- **Owner drops request mid-packet**: owner 3 deasserts `i_request[3]` before `i_free` → grant 5'b01000 retained until `i_free`.
- **Spurious free and reset**:
  - `i_free` pulse while IDLE → no change.
  - `rst_n` low while BUSY (owner 2) → `o_grant`=0 immediately.
  - After release of reset, all requests high → port 0 granted first.
- **Wrap-around**: `last`=4, requests 5'b00001 → port 0 granted. `last` becomes 0; next arbitration scans from port 1.

Source files
------------

// File: rtl/tnoc_output_arbiter_pkg.sv
// Shared types for the router output arbitration path: the grant vector
// and the arbiter state, reused by router monitors and assertions.
package tnoc_output_arbiter_pkg;

    // Number of input ports competing for one router output.
    localparam int TNOC_REQUESTERS = 5;

    // One-hot (or zero) grant vector that steers the output switch mux.
    typedef logic [TNOC_REQUESTERS-1:0] tnoc_grant_t;

    // Packet ownership state of one output port.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tnoc_round_robin_selector.sv
// Combinational round-robin pick: scans the request vector starting one
// past the most recently granted index, wrapping at REQUESTERS-1, and
// returns the first set request as a one-hot vector plus its index.
module tnoc_round_robin_selector #(
    parameter int REQUESTERS = 5,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] request,
    input  logic [IDX_W-1:0]      last,
    output logic [REQUESTERS-1:0] winner,
    output logic [IDX_W-1:0]      winner_index
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk every port once in rotating priority order and keep the first hit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        winner       = '0;
        winner_index = '0;
        found        = 1'b0;
        idx          = last;
        for (int i = 0; i < REQUESTERS; i++) begin
            // Explicit wrap: REQUESTERS need not be a power of two.
            idx = (idx == IDX_W'(REQUESTERS - 1)) ? '0 : idx + IDX_W'(1);
            if (!found && request[idx]) begin
                found        = 1'b1;
                winner[idx]  = 1'b1;
                winner_index = idx;
            end
        end
    end

endmodule

// File: rtl/tnoc_output_arbiter.sv
// Packet-level owner arbitration for one router output port. Grants one
// input port at a time, holds the grant until the switch reports that the
// tail flit has left, then hands over to the next requester round-robin
// in the same cycle so back-to-back packets see no bubble.
module tnoc_output_arbiter
    import tnoc_output_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQUESTERS-1:0] i_request,
    input  logic                  i_free,
    output logic [REQUESTERS-1:0] o_grant,
    output logic                  o_busy
);

    localparam int IDX_W = $clog2(REQUESTERS);

    arb_state_t            state_q;
    logic [REQUESTERS-1:0] grant_q;
    logic [IDX_W-1:0]      last_q;
    logic [REQUESTERS-1:0] sel_request;
    logic [REQUESTERS-1:0] winner;
    logic [IDX_W-1:0]      winner_index;

    // While a packet is in flight, mask the owner so a release hands over to
    // someone else; the owner's bit belongs to its next packet.
    always_comb begin
        sel_request = (state_q == BUSY) ? (i_request & ~grant_q) : i_request;
    end

    tnoc_round_robin_selector #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_selector (
        .request      (sel_request),
        .last         (last_q),
        .winner       (winner),
        .winner_index (winner_index)
    );

    // Ownership state, grant and round-robin pointer; port 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(REQUESTERS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|winner) begin
                        state_q <= BUSY;
                        grant_q <= winner;
                        last_q  <= winner_index;
                    end
                end
                BUSY: begin
                    if (i_free) begin
                        if (|winner) begin
                            grant_q <= winner;
                            last_q  <= winner_index;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = |grant_q;

    // The grant only ever selects a single switch path.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));

    // A packet in flight keeps its path until the tail flit has gone.
    a_grant_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BUSY && !i_free) |=> $stable(grant_q));

endmodule

// File: tb/tb_tnoc_output_arbiter.sv
// Self-checking bench for tnoc_output_arbiter: a port-index/queue-level
// model of packet ownership is compared against the DUT every cycle, and
// directed scenarios pin both the DUT and the model to literal grants.
module tb_tnoc_output_arbiter;
    import tnoc_output_arbiter_pkg::*;

    localparam int N = TNOC_REQUESTERS;

    logic        clk;
    logic        rst_n;
    tnoc_grant_t i_request;
    logic        i_free;
    tnoc_grant_t o_grant;
    logic        o_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: current owner port (-1 when none) and last granted port.
    int m_owner = -1;
    int m_last  = N - 1;

    tnoc_output_arbiter #(.REQUESTERS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_request (i_request),
        .i_free    (i_free),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting port after 'from', modulo N, skipping 'excl'; -1 if none.
    function automatic int pick(input tnoc_grant_t req, input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (from + k) % N;
            if (req[p] && p != excl) return p;
        end
        return -1;
    endfunction

    function automatic tnoc_grant_t model_grant();
        tnoc_grant_t g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // Ownership model: take a packet when idle, hand over on tail-flit release.
    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            w = pick(i_request, m_last, -1);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
            end
        end else if (i_free) begin
            w = pick(i_request, m_last, m_owner);
            m_owner = w;
            if (w >= 0) m_last = w;
        end
    end

    // Every-cycle comparison, sampled away from the active edge.
    always @(negedge clk) begin
        check("cycle_grant", 32'(o_grant), 32'(model_grant()));
        check("cycle_busy", 32'(o_busy), 32'(m_owner >= 0));
    end

    // Apply inputs for one cycle; returns just after the edge that used them.
    task automatic cyc(input tnoc_grant_t req, input logic free);
        i_request = req;
        i_free    = free;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation on both the DUT and the model.
    task automatic expect_grant(input string name, input tnoc_grant_t lit);
        check({name, "_dut"}, 32'(o_grant), 32'(lit));
        check({name, "_model"}, 32'(model_grant()), 32'(lit));
        check({name, "_busy"}, 32'(o_busy), 32'(|lit));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("reset_async_grant", 32'(o_grant), 32'd0);
        check("reset_async_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tnoc_grant_t fair_order [6];
        fair_order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

        rst_n     = 1'b0;
        i_request = '0;
        i_free    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_grant("reset_state", 5'b00000);
        rst_n = 1'b1;

        // Single request, held for three cycles, then released.
        cyc(5'b00100, 1'b0);
        expect_grant("single_grant", 5'b00100);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00100, 1'b0);
            expect_grant("single_hold", 5'b00100);
        end
        cyc(5'b00000, 1'b1);
        expect_grant("single_release", 5'b00000);

        // Fairness from reset: all requesting, free every second cycle.
        reset_dut();
        cyc(5'b11111, 1'b0);
        expect_grant("fair_first", fair_order[0]);
        for (int k = 0; k < 5; k++) begin
            cyc(5'b11111, 1'b1);
            expect_grant("fair_handover", fair_order[k+1]);
            cyc(5'b11111, 1'b0);
            expect_grant("fair_hold", fair_order[k+1]);
        end
        cyc(5'b00000, 1'b1);
        expect_grant("fair_release", 5'b00000);

        // Back-to-back handover from owner 1 to port 3.
        cyc(5'b01010, 1'b0);
        expect_grant("b2b_owner1", 5'b00010);
        cyc(5'b01010, 1'b1);
        expect_grant("b2b_handover", 5'b01000);

        // Owner 3 drops its request mid-packet; grant retained until free.
        cyc(5'b00000, 1'b0);
        expect_grant("drop_hold0", 5'b01000);
        cyc(5'b00010, 1'b0);
        expect_grant("drop_hold1", 5'b01000);
        cyc(5'b00010, 1'b1);
        expect_grant("drop_handover", 5'b00010);
        cyc(5'b00000, 1'b1);
        expect_grant("drop_release", 5'b00000);

        // Spurious free while idle.
        cyc(5'b00000, 1'b1);
        expect_grant("spurious_free0", 5'b00000);
        cyc(5'b00000, 1'b1);
        expect_grant("spurious_free1", 5'b00000);

        // Reset asserted while port 2 owns the output.
        cyc(5'b00100, 1'b0);
        expect_grant("pre_reset_owner2", 5'b00100);
        reset_dut();
        cyc(5'b11111, 1'b0);
        expect_grant("post_reset_port0", 5'b00001);
        cyc(5'b00000, 1'b1);
        expect_grant("post_reset_release", 5'b00000);

        // Wrap-around: last=4 then lone request from port 0.
        cyc(5'b10000, 1'b0);
        expect_grant("wrap_owner4", 5'b10000);
        cyc(5'b00000, 1'b1);
        expect_grant("wrap_idle", 5'b00000);
        cyc(5'b00001, 1'b0);
        expect_grant("wrap_port0", 5'b00001);
        cyc(5'b10011, 1'b1);
        expect_grant("wrap_scan_from1", 5'b00010);
        cyc(5'b00000, 1'b1);
        expect_grant("wrap_release", 5'b00000);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
